// File: rtl/user_counter_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : user_counter_pkg
// Description : Register offsets, CTRL bit indices and the byte-strobe merge
//               helper shared by the user_counter_bank files.
// Revision    : 1.0 - initial release
// ============================================================================
package user_counter_pkg;

    localparam logic [7:0] c_ch_stride   = 8'h10;
    localparam logic [3:0] c_ofs_ctrl    = 4'h0;
    localparam logic [3:0] c_ofs_count   = 4'h4;
    localparam logic [3:0] c_ofs_limit   = 4'h8;
    localparam logic [3:0] c_ofs_status  = 4'hC;
    localparam logic [7:0] c_adr_io_sel  = 8'h80;

    localparam int c_ctrl_en        = 0;
    localparam int c_ctrl_dir       = 1;
    localparam int c_ctrl_reload    = 2;
    localparam int c_ctrl_irq_en    = 3;
    localparam int c_ctrl_presc_lsb = 8;
    localparam int c_status_hit     = 0;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  sel);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/user_counter_bank_if.sv
`default_nettype none
// ============================================================================
// Module      : user_counter_bank_if
// Description : Wishbone slave bundle for the counter bank.
// Revision    : 1.0 - initial release
// ============================================================================
interface user_counter_bank_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface
`default_nettype wire

// File: rtl/user_counter_bank_channel.sv
`default_nettype none
// ============================================================================
// Module      : counter_channel
// Description : One counter channel: CTRL/COUNT/LIMIT/HIT, tick logic and the
//               WB > LA > tick count priority. Prescaler under
//               USER_COUNTER_PRESCALER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_channel
    import user_counter_pkg::*;
#(
    parameter int WIDTH      = 30,
    parameter int COUNT_STEP = 1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_wr_ctrl,
    input  wire logic             i_wr_count,
    input  wire logic             i_wr_limit,
    input  wire logic             i_wr_status,
    input  wire logic [31:0]      i_wdata,
    input  wire logic [3:0]       i_wsel,
    input  wire logic             i_la_load,
    input  wire logic [WIDTH-1:0] i_la_mask,
    input  wire logic [WIDTH-1:0] i_la_data,
    output logic [31:0]           o_ctrl,
    output logic [WIDTH-1:0]      o_count,
    output logic [WIDTH-1:0]      o_limit,
    output logic                  o_hit,
    output logic                  o_irq_req
);

    localparam logic [WIDTH-1:0] c_step = WIDTH'(COUNT_STEP);

    logic             en_q, en_d;
    logic             dir_q, dir_d;
    logic             reload_q, reload_d;
    logic             irq_en_q, irq_en_d;
    logic             hit_q, hit_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] limit_q, limit_d;

    logic [31:0]      w_ctrl_cur;
    logic [31:0]      w_ctrl_wr;
    logic [31:0]      w_count_wr;
    logic [31:0]      w_limit_wr;
    logic [WIDTH-1:0] w_count_tick;
    logic             w_tick;
    logic             w_hit_set;
    logic             w_stop;
    logic             w_hit_clr;

`ifdef USER_COUNTER_PRESCALER_EN
    logic [7:0] presc_q, presc_d;
    logic [7:0] presc_cnt_q, presc_cnt_d;
`endif

    always_comb begin
        w_ctrl_cur                 = '0;
        w_ctrl_cur[c_ctrl_en]      = en_q;
        w_ctrl_cur[c_ctrl_dir]     = dir_q;
        w_ctrl_cur[c_ctrl_reload]  = reload_q;
        w_ctrl_cur[c_ctrl_irq_en]  = irq_en_q;
`ifdef USER_COUNTER_PRESCALER_EN
        w_ctrl_cur[c_ctrl_presc_lsb +: 8] = presc_q;
`endif
        w_ctrl_wr  = byte_merge(w_ctrl_cur, i_wdata, i_wsel);
        w_count_wr = byte_merge(32'(count_q), i_wdata, i_wsel);
        w_limit_wr = byte_merge(32'(limit_q), i_wdata, i_wsel);

`ifdef USER_COUNTER_PRESCALER_EN
        w_tick = en_q && (presc_cnt_q == presc_q);
        if (!en_q || i_wr_ctrl || w_tick) presc_cnt_d = '0;
        else                              presc_cnt_d = presc_cnt_q + 8'd1;
        presc_d = i_wr_ctrl ? w_ctrl_wr[c_ctrl_presc_lsb +: 8] : presc_q;
`else
        w_tick = en_q;
`endif

        w_hit_set    = 1'b0;
        w_stop       = 1'b0;
        w_count_tick = count_q;
        if (w_tick) begin
            if (!dir_q) begin
                if (count_q >= limit_q) begin
                    w_hit_set = 1'b1;
                    if (reload_q) w_count_tick = '0;
                    else          w_stop       = 1'b1;
                end else begin
                    w_count_tick = count_q + c_step;
                end
            end else begin
                if (count_q == '0) begin
                    w_hit_set = 1'b1;
                    if (reload_q) w_count_tick = limit_q;
                    else          w_stop       = 1'b1;
                end else if (count_q >= c_step) begin
                    w_count_tick = count_q - c_step;
                end else begin
                    w_count_tick = '0;
                end
            end
        end

        if (i_wr_count)     count_d = w_count_wr[WIDTH-1:0];
        else if (i_la_load) count_d = (count_q & ~i_la_mask) | (i_la_data & i_la_mask);
        else                count_d = w_count_tick;

        limit_d = i_wr_limit ? w_limit_wr[WIDTH-1:0] : limit_q;

        // A CTRL write in the one-shot stop cycle keeps whatever EN it wrote.
        en_d     = en_q;
        dir_d    = dir_q;
        reload_d = reload_q;
        irq_en_d = irq_en_q;
        if (i_wr_ctrl) begin
            en_d     = w_ctrl_wr[c_ctrl_en];
            dir_d    = w_ctrl_wr[c_ctrl_dir];
            reload_d = w_ctrl_wr[c_ctrl_reload];
            irq_en_d = w_ctrl_wr[c_ctrl_irq_en];
        end else if (w_stop) begin
            en_d = 1'b0;
        end

        w_hit_clr = i_wr_status & i_wsel[0] & i_wdata[c_status_hit];
        hit_d     = w_hit_set | (hit_q & ~w_hit_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q     <= 1'b0;
            dir_q    <= 1'b0;
            reload_q <= 1'b0;
            irq_en_q <= 1'b0;
            hit_q    <= 1'b0;
            count_q  <= '0;
            limit_q  <= '1;
`ifdef USER_COUNTER_PRESCALER_EN
            presc_q     <= '0;
            presc_cnt_q <= '0;
`endif
        end else begin
            en_q     <= en_d;
            dir_q    <= dir_d;
            reload_q <= reload_d;
            irq_en_q <= irq_en_d;
            hit_q    <= hit_d;
            count_q  <= count_d;
            limit_q  <= limit_d;
`ifdef USER_COUNTER_PRESCALER_EN
            presc_q     <= presc_d;
            presc_cnt_q <= presc_cnt_d;
`endif
        end
    end

    assign o_ctrl    = w_ctrl_cur;
    assign o_count   = count_q;
    assign o_limit   = limit_q;
    assign o_hit     = hit_q;
    assign o_irq_req = hit_q & irq_en_q;

    logic w_unused_ok;
    assign w_unused_ok = ^{i_wdata, i_wsel, w_ctrl_wr, w_count_wr, w_limit_wr};

endmodule
`default_nettype wire

// File: rtl/user_counter_bank.sv
`default_nettype none
// ============================================================================
// Module      : user_counter_bank
// Description : N_CH counter channels behind a Wishbone slave with LA load,
//               soft reset, IRQ and io_out channel select.
//               Optional prescaler: define USER_COUNTER_PRESCALER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module user_counter_bank
    import user_counter_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int WIDTH      = 30,
    parameter int COUNT_STEP = 1
) (
    input  wire logic         wb_clk_i,
    input  wire logic         wb_rst_i,
    user_counter_bank_if.slave wb,
    input  wire logic [31:0]  la_data_in,
    input  wire logic [31:0]  la_oenb,
    output logic [35:0]       io_out,
    output logic [35:0]       io_oeb,
    output logic [2:0]        user_irq
);

    localparam logic [35:0] c_oeb = {{(36-WIDTH){1'b1}}, {WIDTH{1'b0}}};

    logic        rst;
    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;
    logic [2:0]  io_sel_q, io_sel_d;
    logic        irq_q, irq_d;

    logic        w_valid;
    logic        w_wr;
    logic [7:0]  w_adr;
    logic [2:0]  w_ch_idx;
    logic [3:0]  w_ofs;
    logic        w_ch_space;
    logic        w_io_sel_hit;
    logic        w_la_load;
    logic [31:0] w_rdata;
    logic [WIDTH-1:0] w_io_count;

    logic [31:0]      w_ch_ctrl  [N_CH];
    logic [WIDTH-1:0] w_ch_count [N_CH];
    logic [WIDTH-1:0] w_ch_limit [N_CH];
    logic [N_CH-1:0]  w_ch_hit;
    logic [N_CH-1:0]  w_ch_irq;

    // LA bit 31 acts as a soft reset identical to wb_rst_i.
    assign rst = wb_rst_i | (~la_oenb[31] & la_data_in[31]);

    assign w_valid      = wb.wbs_cyc_i & wb.wbs_stb_i;
    assign w_wr         = w_valid & wb.wbs_we_i & ack_q;
    assign w_adr        = wb.wbs_adr_i[7:0];
    assign w_ch_idx     = 3'(w_adr / c_ch_stride);
    assign w_ofs        = 4'(w_adr % c_ch_stride);
    assign w_ch_space   = ~w_adr[7] & ({1'b0, w_ch_idx} < 4'(N_CH));
    assign w_io_sel_hit = (w_adr == c_adr_io_sel);
    assign w_la_load    = ~w_valid;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic w_sel;
        assign w_sel = w_wr & w_ch_space & (w_ch_idx == 3'(c));

        counter_channel #(
            .WIDTH      (WIDTH),
            .COUNT_STEP (COUNT_STEP)
        ) u_channel (
            .clk         (wb_clk_i),
            .rst         (rst),
            .i_wr_ctrl   (w_sel & (w_ofs == c_ofs_ctrl)),
            .i_wr_count  (w_sel & (w_ofs == c_ofs_count)),
            .i_wr_limit  (w_sel & (w_ofs == c_ofs_limit)),
            .i_wr_status (w_sel & (w_ofs == c_ofs_status)),
            .i_wdata     (wb.wbs_dat_i),
            .i_wsel      (wb.wbs_sel_i),
            .i_la_load   ((c == 0) ? w_la_load : 1'b0),
            .i_la_mask   (~la_oenb[WIDTH-1:0]),
            .i_la_data   (la_data_in[WIDTH-1:0]),
            .o_ctrl      (w_ch_ctrl[c]),
            .o_count     (w_ch_count[c]),
            .o_limit     (w_ch_limit[c]),
            .o_hit       (w_ch_hit[c]),
            .o_irq_req   (w_ch_irq[c])
        );
    end

    always_comb begin
        w_rdata = '0;
        if (w_io_sel_hit) begin
            w_rdata = 32'(io_sel_q);
        end else if (w_ch_space) begin
            for (int c = 0; c < N_CH; c++) begin
                if (w_ch_idx == 3'(c)) begin
                    case (w_ofs)
                        c_ofs_ctrl:   w_rdata = w_ch_ctrl[c];
                        c_ofs_count:  w_rdata = 32'(w_ch_count[c]);
                        c_ofs_limit:  w_rdata = 32'(w_ch_limit[c]);
                        c_ofs_status: w_rdata = 32'(w_ch_hit[c]);
                        default:      w_rdata = '0;
                    endcase
                end
            end
        end
    end

    always_comb begin
        w_io_count = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (io_sel_q == 3'(c)) w_io_count = w_ch_count[c];
        end
    end

    always_comb begin
        ack_d    = w_valid & ~ack_q;
        dat_d    = (w_valid & ~ack_q) ? w_rdata : '0;
        io_sel_d = (w_wr & w_io_sel_hit & wb.wbs_sel_i[0]) ? wb.wbs_dat_i[2:0] : io_sel_q;
        irq_d    = |w_ch_irq;
    end

    always_ff @(posedge wb_clk_i) begin
        if (rst) begin
            ack_q    <= 1'b0;
            dat_q    <= '0;
            io_sel_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            ack_q    <= ack_d;
            dat_q    <= dat_d;
            io_sel_q <= io_sel_d;
            irq_q    <= irq_d;
        end
    end

    assign wb.wbs_ack_o = ack_q;
    assign wb.wbs_dat_o = dat_q;
    assign io_out       = 36'(w_io_count);
    assign io_oeb       = c_oeb;
    assign user_irq     = {2'b00, irq_q};

    logic w_unused_ok;
    assign w_unused_ok = ^{wb.wbs_adr_i[31:8], la_data_in, la_oenb, w_ch_hit};

endmodule
`default_nettype wire

// File: doc/user_counter_bank.md
Name: user_counter_bank

Overview:
- Parametrised successor to the single user-area counter.
- N_CH independent WIDTH-bit counter channels, each with a limit, up/down mode, auto-reload or one-shot, sticky hit flag and interrupt enable.
- Sits in the user project area as a Wishbone slave. Logic-analyzer access can soft-reset the block and load channel 0.
- One Wishbone-selectable channel drives io_out.

Parameters:
- N_CH, 4, number of channels (1..8).
- WIDTH, 30, counter width (1..30).
- COUNT_STEP, 1, increment/decrement per enabled tick (1..2^WIDTH-1).

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  synchronous, active-high reset.
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone strobe/cycle/write.
- wbs_sel_i  in  4  byte strobes.
- wbs_dat_i  in  32  write data.
- wbs_adr_i  in  32  address; only [7:0] decoded.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- la_data_in  in  32  LA data.
- la_oenb  in  32  LA output-enable, active-low (0 = LA drives).
- io_out  out  36  selected channel count.
- io_oeb  out  36  pad output-enable, active-low.
- user_irq  out  3  interrupts.

Behaviour:
- Clock/reset: one clock, wb_clk_i. Reset is synchronous and active-high on wb_rst_i. Soft reset: when la_oenb[31]=0 and la_data_in[31]=1, the block resets exactly as for wb_rst_i.
- Reset values: COUNT=0, LIMIT=all ones, CTRL=0, HIT=0, IO_SEL=0, wbs_ack_o=0, wbs_dat_o=0, user_irq=0, io_out=0.
- Register map, per channel c (c<N_CH), base c*0x10:
  - +0x0 CTRL: bit0 EN, bit1 DIR (1=down), bit2 RELOAD, bit3 IRQ_EN.
  - +0x4 COUNT.
  - +0x8 LIMIT.
  - +0xC STATUS: bit0 HIT, write-1-to-clear.
- Global register at 0x80: IO_SEL[2:0].
- Unmapped or out-of-range addresses: reads return 0, writes are ignored, ack still issued.
- Handshake:
  - valid = cyc & stb.
  - wbs_ack_o <= valid & ~wbs_ack_o, giving a one-cycle pulse one cycle after valid.
  - Writes commit on the ack cycle under wbs_sel_i byte strobes.
  - wbs_dat_o is registered and valid during ack.
  - Master must drop stb after ack.
- Tick (channel EN=1), up mode:
  - If COUNT >= LIMIT: HIT<=1, and COUNT<=0 if RELOAD, else COUNT holds and EN<=0.
  - Otherwise COUNT<=(COUNT+COUNT_STEP) mod 2^WIDTH.
- Tick, down mode:
  - If COUNT==0: HIT<=1, and COUNT<=LIMIT if RELOAD, else EN<=0.
  - Otherwise COUNT<=max(COUNT-COUNT_STEP, 0).
- Count priority, per channel per cycle: WB write to COUNT > LA load (channel 0 only) > tick.
- LA load: channel 0 COUNT[i]<=la_data_in[i] for each i<WIDTH with la_oenb[i]=0. Applies only in cycles with no WB valid.
- HIT: a set event in the same cycle as a W1C write wins (HIT stays 1). A WB write to CTRL with EN=1 in a one-shot stop cycle leaves EN=1.
- user_irq[0] = OR over c of (HIT[c] & IRQ_EN[c]), registered, so it lags HIT by one cycle. user_irq[2:1]=0.
- IO:
  - io_out[WIDTH-1:0] = COUNT[IO_SEL]. IO_SEL>=N_CH drives 0.
  - io_out[35:WIDTH]=0.
  - io_oeb[WIDTH-1:0]=0; io_oeb[35:WIDTH]=all ones.

Optional Feature:
- Macro: USER_COUNTER_PRESCALER_EN.
- Defined: CTRL[15:8] is PRESC, reset 0. Each channel has an 8-bit prescale counter. A tick occurs once every PRESC+1 cycles with EN=1. The prescale counter clears when EN=0 or when CTRL is written.
- Undefined: a tick occurs every EN=1 cycle, and CTRL[15:8] reads 0.

Decomposition:
- Package user_counter_pkg holds:
  - register offsets (CTRL/COUNT/LIMIT/STATUS, IO_SEL=0x80);
  - CTRL bit indices;
  - the channel stride 0x10.
- Sub-module counter_channel (one per channel, generate loop) holds CTRL/COUNT/LIMIT/HIT, the tick logic, the prescaler and the priority mux.
- Top level holds Wishbone decode, ack, read mux, LA handling, IRQ and IO mux.

Test Plan:
- Reset: wb_rst_i=1 for 2 cycles. Then all reads give COUNT=0, LIMIT=0x3FFFFFFF, CTRL=0, STATUS=0, and io_out=0, io_oeb=36'hFC0000000, user_irq=0.
- Up auto-reload: CH1 LIMIT=5, CTRL=0xD. COUNT runs 0,1,2,3,4,5,0. HIT=1 at wrap and user_irq[0]=1 one cycle later. W1C to STATUS clears both.
- Down one-shot: CH2 COUNT=3, LIMIT=10, CTRL=0x3. COUNT runs 3,2,1,0, then HIT=1, CTRL.EN reads 0 and COUNT holds 0.
- Byte strobes: write 0xAABBCCDD to CH0 LIMIT with sel=4'b0010. LIMIT=0x3FFFCCFF. Ack is a single pulse, one cycle after stb.
- LA path:
  - la_oenb[7:0]=0, la_data_in[7:0]=0x5A, no WB: CH0 COUNT[7:0]=0x5A next cycle.
  - Simultaneous WB write of COUNT=0x100: COUNT=0x100.
  - la_oenb[31]=0, la_data_in[31]=1: full reset.
- IO select: IO_SEL=2 with CH2 counting. io_out[29:0] tracks CH2 COUNT. IO_SEL=7 (N_CH=4) gives io_out=0.
